sq_carry_normalize: RTL and testbench

- Downstream of the lower-half column summers in the MSU squaring datapath.
- Takes one vector of column sums, each SUM_BITS wide. Normalises it by iterative carry passes into redundant coefficients of WORD_BITS+1 bits.
- The polynomial reduction stage consumes these coefficients.
- Multi-cycle, non-overlapped; valid/ready on both sides.

---
 rtl/sq_carry_normalize_pkg.sv | 24 ++
 rtl/sq_carry_pass.sv | 44 ++++
 rtl/sq_carry_normalize.sv | 126 ++++++++++++
 tb/tb_sq_carry_normalize.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sq_carry_normalize_pkg.sv
// rtl/sq_carry_normalize_pkg.sv - shared constants and types for the squaring carry normaliser
//
// Purpose: default widths, pass count and FSM state type used by
// sq_carry_normalize and sq_carry_pass.
// Ports: none (package).
// Optional feature macro consumed by the importing top: MSU_CARRY_EARLY_EXIT_EN.

package sq_carry_normalize_pkg;

  localparam int WordBits     = 16;
  localparam int SqSumBits    = 20;
  localparam int SqNormCols   = 8;
  localparam int SqNormPasses = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DONE = 2'd2
  } sq_norm_state_e;

  // One redundant output coefficient: a full word plus one carry bit.
  typedef logic [WordBits:0] sq_coeff_t;

endpackage

// File: rtl/sq_carry_pass.sv
// rtl/sq_carry_pass.sv - one combinational carry-propagation pass over the column array
//
// Purpose: splits every column below the top into lo/hi halves and adds each
// hi half into the next column up; the top column absorbs hi of the column
// below it and is never split itself.
// Ports:
//   cols        in   (NUM_COLS+1) x SUM_BITS  current column values
//   cols_next   out  (NUM_COLS+1) x SUM_BITS  column values after one pass
//   all_hi_zero out  1                        no column below the top has hi bits set

module sq_carry_pass
  import sq_carry_normalize_pkg::*;
#(
  parameter int NUM_COLS  = SqNormCols,
  parameter int SUM_BITS  = SqSumBits,
  parameter int WORD_BITS = WordBits
) (
  input  logic [NUM_COLS:0][SUM_BITS-1:0] cols,
  output logic [NUM_COLS:0][SUM_BITS-1:0] cols_next,
  output logic                            all_hi_zero
);

  always_comb begin
    cols_next   = '0;
    all_hi_zero = 1'b1;

    cols_next[0] = SUM_BITS'(cols[0][WORD_BITS-1:0]);
    for (int k = 1; k < NUM_COLS; k++) begin
      // lo is at most 2^WORD_BITS-1 and hi is narrower than a word,
      // so the sum always fits back into SUM_BITS.
      cols_next[k] = SUM_BITS'(cols[k][WORD_BITS-1:0])
                   + SUM_BITS'(cols[k-1][SUM_BITS-1:WORD_BITS]);
    end
    cols_next[NUM_COLS] = cols[NUM_COLS]
                        + SUM_BITS'(cols[NUM_COLS-1][SUM_BITS-1:WORD_BITS]);

    for (int k = 0; k < NUM_COLS; k++) begin
      if (cols[k][SUM_BITS-1:WORD_BITS] != '0) begin
        all_hi_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sq_carry_normalize.sv
// rtl/sq_carry_normalize.sv - iterative carry normaliser from column sums to redundant coefficients
//
// Purpose: accepts one vector of column sums, runs NUM_PASSES carry passes
// (one per clock), then holds the (WORD_BITS+1)-bit coefficients until the
// consumer takes them. Vectors are never overlapped.
// Optional feature: MSU_CARRY_EARLY_EXIT_EN - leave PASS as soon as a pass
// would change nothing; results are identical, only latency shrinks.
// Ports:
//   clk_i     in   1                           clock
//   rst_i     in   1                           synchronous active-high reset
//   sums_i    in   NUM_COLS x SUM_BITS         column sums
//   valid_i   in   1                           sums_i valid
//   ready_o   out  1                           block can accept (IDLE only)
//   coeffs_o  out  (NUM_COLS+1) x (WORD_BITS+1) coefficients; index NUM_COLS is the top carry column
//   valid_o   out  1                           coeffs_o valid (DONE)
//   ready_i   in   1                           consumer accepts

module sq_carry_normalize
  import sq_carry_normalize_pkg::*;
#(
  parameter int NUM_COLS   = SqNormCols,
  parameter int SUM_BITS   = SqSumBits,
  parameter int WORD_BITS  = WordBits,
  parameter int NUM_PASSES = SqNormPasses
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_COLS-1:0][SUM_BITS-1:0]  sums_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic [NUM_COLS:0][WORD_BITS:0]     coeffs_o,
  output logic                               valid_o,
  input  logic                               ready_i
);

  localparam int CNT_BITS = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  sq_norm_state_e                  state, state_next;
  logic [CNT_BITS-1:0]             pass_cnt, pass_cnt_next;
  logic [NUM_COLS:0][SUM_BITS-1:0] col, col_next, col_pass;
  logic                            all_hi_zero;
  logic                            early_exit;

  sq_carry_pass #(
    .NUM_COLS  (NUM_COLS),
    .SUM_BITS  (SUM_BITS),
    .WORD_BITS (WORD_BITS)
  ) u_pass (
    .cols        (col),
    .cols_next   (col_pass),
    .all_hi_zero (all_hi_zero)
  );

`ifdef MSU_CARRY_EARLY_EXIT_EN
  // A pass with no hi bits below the top column is an identity, so stop.
  assign early_exit = all_hi_zero;
`else
  // The flag is only consumed by the early-exit build.
  logic all_hi_zero_unused;
  assign all_hi_zero_unused = all_hi_zero;
  assign early_exit         = 1'b0;
`endif

  always_comb begin
    state_next    = state;
    pass_cnt_next = pass_cnt;
    col_next      = col;
    ready_o       = 1'b0;
    valid_o       = 1'b0;

    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          for (int k = 0; k < NUM_COLS; k++) begin
            col_next[k] = sums_i[k];
          end
          col_next[NUM_COLS] = '0;
          pass_cnt_next      = '0;
          state_next         = PASS;
        end
      end
      PASS: begin
        if (early_exit) begin
          pass_cnt_next = '0;
          state_next    = DONE;
        end else begin
          col_next      = col_pass;
          pass_cnt_next = pass_cnt + 1'b1;
          if (pass_cnt == CNT_BITS'(NUM_PASSES - 1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The top column is kept at SUM_BITS internally; legal parameters keep
  // its value inside WORD_BITS+1 bits, so truncation loses nothing.
  always_comb begin
    coeffs_o = '0;
    for (int k = 0; k <= NUM_COLS; k++) begin
      coeffs_o[k] = col[k][WORD_BITS:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      pass_cnt <= '0;
      col      <= '0;
    end else begin
      state    <= state_next;
      pass_cnt <= pass_cnt_next;
      col      <= col_next;
    end
  end

endmodule

// File: tb/tb_sq_carry_normalize.sv
// tb/tb_sq_carry_normalize.sv - scoreboard bench for sq_carry_normalize

module tb_sq_carry_normalize;

  localparam int NC  = 8;
  localparam int SB  = 20;
  localparam int WB  = 16;
  localparam int NP  = 2;

  typedef struct packed {
    logic [NC:0][WB:0] c;
    int                acc;
    int                lat;
    logic [191:0]      val;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_i = 1'b1;
  logic [NC-1:0][SB-1:0]    sums_i = '0;
  logic                     valid_i = 1'b0;
  logic                     ready_o;
  logic [NC:0][WB:0]        coeffs_o;
  logic                     valid_o;
  logic                     ready_i = 1'b0;

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  bit   rand_ready = 1'b0;
  exp_t q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   prev_valid = 1'b0;

  sq_carry_normalize #(
    .NUM_COLS(NC), .SUM_BITS(SB), .WORD_BITS(WB), .NUM_PASSES(NP)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .sums_i(sums_i), .valid_i(valid_i),
    .ready_o(ready_o), .coeffs_o(coeffs_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    #1;
    if (rand_ready) ready_i = ($urandom % 3) != 0;
  end

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: each pass moves everything above the low word of a column into
  // the column above, using integer division/modulo; the top column only grows.
  function automatic exp_t model(input logic [NC-1:0][SB-1:0] v, input int acc);
    exp_t   e;
    longint c[NC+1];
    longint n[NC+1];
    longint base = 64'd1 << WB;
    e.val = '0;
    for (int k = 0; k < NC; k++) begin
      c[k] = longint'(v[k]);
      e.val += 192'(v[k]) << (WB * k);
    end
    c[NC] = 0;
    e.lat = NP;
`ifdef MSU_CARRY_EARLY_EXIT_EN
    begin
      bit found = 1'b0;
      longint t[NC+1];
      t = c;
      for (int p = 0; p < NP; p++) begin
        bit small = 1'b1;
        for (int k = 0; k < NC; k++) if (t[k] >= base) small = 1'b0;
        if (small && !found) begin
          e.lat = p + 1;
          found = 1'b1;
        end
        n[0] = t[0] % base;
        for (int k = 1; k < NC; k++) n[k] = t[k] % base + t[k-1] / base;
        n[NC] = t[NC] + t[NC-1] / base;
        t = n;
      end
    end
`endif
    for (int p = 0; p < NP; p++) begin
      n[0] = c[0] % base;
      for (int k = 1; k < NC; k++) n[k] = c[k] % base + c[k-1] / base;
      n[NC] = c[NC] + c[NC-1] / base;
      c = n;
    end
    for (int k = 0; k <= NC; k++) e.c[k] = (WB+1)'(c[k] % (base * 2));
    e.acc = acc;
    return e;
  endfunction

  function automatic logic [191:0] coeff_value(input logic [NC:0][WB:0] c);
    logic [191:0] s = '0;
    for (int k = 0; k <= NC; k++) s += 192'(c[k]) << (WB * k);
    return s;
  endfunction

  always @(negedge clk) begin
    if (rst_i) begin
      prev_valid = 1'b0;
      have_cur   = 1'b0;
    end else if (valid_o) begin
      if (!prev_valid) begin
        if (q.size() == 0) begin
          have_cur = 1'b0;
          check("unexpected_valid", 1, 0);
        end else begin
          cur      = q.pop_front();
          have_cur = 1'b1;
          check("latency", 192'(cycle - cur.acc), 192'(cur.lat));
          check("value_preserved", coeff_value(coeffs_o), cur.val);
        end
      end
      if (have_cur) check("coeffs", 192'(coeffs_o), 192'(cur.c));
      check("ready_o_busy", 192'(ready_o), 0);
      prev_valid = 1'b1;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic send(input logic [NC-1:0][SB-1:0] v, input bit expect_out);
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      check("send_timeout", 0, 1);
      return;
    end
    sums_i  = v;
    valid_i = 1'b1;
    if (expect_out) q.push_back(model(v, cycle + 1));
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    for (int k = 0; k < NC; k++) sums_i[k] = SB'($urandom);
  endtask

  initial begin
    logic [NC-1:0][SB-1:0] v;
    int n;

    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset_ready_o", 192'(ready_o), 1);
    check("reset_valid_o", 192'(valid_o), 0);
    check("reset_coeffs_o", 192'(coeffs_o), 0);

    // Single carry under backpressure, with ignored valid_i pulses.
    ready_i = 1'b0;
    v = '0;
    v[0] = 20'h10005;
    send(v, 1'b1);
    n = 0;
    while (!valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach_done", 192'(valid_o), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 192'(valid_o), 1);
      valid_i = i[0];
      for (int k = 0; k < NC; k++) sums_i[k] = SB'($urandom);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    check("bp_release_ready_o", 192'(ready_o), 1);
    check("bp_release_valid_o", 192'(valid_o), 0);

    // Saturation, accepted right after the release.
    for (int k = 0; k < NC; k++) v[k] = 20'hFFFFF;
    send(v, 1'b1);
    rand_ready = 1'b1;

    // All columns already below one word.
    for (int k = 0; k < NC; k++) v[k] = SB'($urandom_range(0, 16'hFFFF));
    send(v, 1'b1);

    // Reset on the first pass edge discards the vector.
    for (int k = 0; k < NC; k++) v[k] = SB'($urandom);
    send(v, 1'b0);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("midpass_rst_ready_o", 192'(ready_o), 1);
    check("midpass_rst_valid_o", 192'(valid_o), 0);
    check("midpass_rst_coeffs_o", 192'(coeffs_o), 0);
    repeat (4) @(negedge clk);
    check("midpass_rst_valid_stays_low", 192'(valid_o), 0);

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NC; k++) begin
        if (i % 4 == 0) v[k] = SB'($urandom_range(0, 16'hFFFF));
        else v[k] = SB'($urandom);
      end
      send(v, 1'b1);
    end

    n = 0;
    while ((q.size() != 0 || valid_o) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 192'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
